// File: rtl/perf_counter_bank.sv
// perf_counter_bank: a bank of cycle/event counters with per-channel clear,
// wrap or saturate overflow handling, sticky overflow flags and a one-deep
// request/acknowledge read port. Channel 0 counts non-halted cycles.
module perf_counter_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                                               CLK,
    input  logic                                               start_n,
    input  logic                                               halt,
    input  logic [CHANNELS-1:0]                                evt_en,
    input  logic [CHANNELS-1:0]                                clr,
    input  logic                                               rd_req,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rd_sel,
    output logic                                               rd_ack,
    output logic [WIDTH-1:0]                                   rd_data,
    output logic                                               rd_ovf,
    output logic [CHANNELS-1:0]                                ovf
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        ACK
    } rd_state_t;

    logic [WIDTH-1:0] count [CHANNELS];

    rd_state_t        state;
    rd_state_t        state_next;
    logic             capture;
    logic [WIDTH-1:0] sel_data;
    logic             sel_ovf;

    // Counter bank: clear beats halt, halt beats increment; overflow is sticky.
    always_ff @(posedge CLK) begin
        if (!start_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (clr[i]) begin
                    count[i] <= '0;
                    ovf[i]   <= 1'b0;
                end else if (!halt && (i == 0 || evt_en[i])) begin
                    if (count[i] == MAX_COUNT) begin
                        ovf[i]   <= 1'b1;
                        count[i] <= (SATURATE != 0) ? MAX_COUNT : '0;
                    end else begin
                        count[i] <= count[i] + ONE;
                    end
                end
            end
        end
    end

    // Read FSM next state and selection of the pre-update count/flag to capture.
    always_comb begin
        state_next = IDLE;
        capture    = 1'b0;
        sel_data   = '0;
        sel_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Out-of-range selects match no channel and therefore capture zero.
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_data = count[i];
                sel_ovf  = ovf[i];
            end
        end
    end

    // Read FSM state and registered read outputs.
    always_ff @(posedge CLK) begin
        if (!start_n) begin
            state   <= IDLE;
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_ovf  <= 1'b0;
        end else begin
            state  <= state_next;
            rd_ack <= (state_next == ACK);
            if (capture) begin
                rd_data <= sel_data;
                rd_ovf  <= sel_ovf;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: a wrapping and a saturating instance share
// one stimulus stream and are compared each cycle against a reference model.
module tb_perf_counter_bank;

    localparam int W    = 4;
    localparam int CH   = 5;
    localparam int SW   = 3;
    localparam int MAXV = 15;

    logic          CLK = 1'b0;
    logic          start_n;
    logic          halt;
    logic [CH-1:0] evt_en;
    logic [CH-1:0] clr;
    logic          rd_req;
    logic [SW-1:0] rd_sel;

    logic          ack_w, ack_s;
    logic [W-1:0]  data_w, data_s;
    logic          rovf_w, rovf_s;
    logic [CH-1:0] ovf_w, ovf_s;

    perf_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut_wrap (
        .CLK(CLK), .start_n(start_n), .halt(halt), .evt_en(evt_en), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(ack_w), .rd_data(data_w),
        .rd_ovf(rovf_w), .ovf(ovf_w)
    );

    perf_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut_sat (
        .CLK(CLK), .start_n(start_n), .halt(halt), .evt_en(evt_en), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(ack_s), .rd_data(data_s),
        .rd_ovf(rovf_s), .ovf(ovf_s)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt  [2][CH];
    bit m_ovf  [2][CH];
    bit m_ack  [2];
    int m_data [2];
    bit m_rovf [2];

    typedef struct {
        bit       sn;
        bit       hl;
        bit [4:0] ev;
        bit [4:0] cl;
        bit       rq;
        bit [2:0] sel;
        bit       ack;
        int       data;
        bit       rovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int v = 0; v < 2; v++) begin
            if (!start_n) begin
                for (int c = 0; c < CH; c++) begin
                    m_cnt[v][c] = 0;
                    m_ovf[v][c] = 0;
                end
                m_ack[v]  = 0;
                m_data[v] = 0;
                m_rovf[v] = 0;
            end else begin
                if (m_ack[v]) begin
                    m_ack[v] = 0;
                end else if (rd_req) begin
                    m_ack[v] = 1;
                    if (int'(rd_sel) < CH) begin
                        m_data[v] = m_cnt[v][rd_sel];
                        m_rovf[v] = m_ovf[v][rd_sel];
                    end else begin
                        m_data[v] = 0;
                        m_rovf[v] = 0;
                    end
                end
                for (int c = 0; c < CH; c++) begin
                    if (clr[c]) begin
                        m_cnt[v][c] = 0;
                        m_ovf[v][c] = 0;
                    end else if (!halt && (c == 0 || evt_en[c])) begin
                        int n;
                        n = m_cnt[v][c] + 1;
                        if (n > MAXV) begin
                            m_ovf[v][c] = 1;
                            m_cnt[v][c] = (v == 1) ? MAXV : n % (MAXV + 1);
                        end else begin
                            m_cnt[v][c] = n;
                        end
                    end
                end
            end
        end
    endtask

    function automatic int ovf_vec(input int v);
        int r = 0;
        for (int c = 0; c < CH; c++) if (m_ovf[v][c]) r += (1 << c);
        return r;
    endfunction

    task automatic compare_all();
        check("ack_w",  int'(ack_w),  int'(m_ack[0]));
        check("data_w", int'(data_w), m_data[0]);
        check("rovf_w", int'(rovf_w), int'(m_rovf[0]));
        check("ovf_w",  int'(ovf_w),  ovf_vec(0));
        check("ack_s",  int'(ack_s),  int'(m_ack[1]));
        check("data_s", int'(data_s), m_data[1]);
        check("rovf_s", int'(rovf_s), int'(m_rovf[1]));
        check("ovf_s",  int'(ovf_s),  ovf_vec(1));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        start_n = 1'b0;
        halt    = 1'b0;
        evt_en  = '0;
        clr     = '0;
        rd_req  = 1'b0;
        rd_sel  = '0;
        repeat (n) step();
        start_n = 1'b1;
    endtask

    task automatic pulse_evt(input int ch, input int n);
        repeat (n) begin
            evt_en = '0;
            evt_en[ch] = 1'b1;
            step();
            evt_en = '0;
            step();
        end
    endtask

    task automatic read_expect(input string name, input int sel,
                               input int edw, input int eow,
                               input int eds, input int eos);
        rd_req = 1'b1;
        rd_sel = SW'(sel);
        step();
        rd_req = 1'b0;
        check({name, "_ack_w"},  int'(ack_w),  1);
        check({name, "_data_w"}, int'(data_w), edw);
        check({name, "_ovf_w"},  int'(rovf_w), eow);
        check({name, "_ack_s"},  int'(ack_s),  1);
        check({name, "_data_s"}, int'(data_s), eds);
        check({name, "_ovf_s"},  int'(rovf_s), eos);
        step();
    endtask

    function automatic vec_t mk(input bit sn, input bit hl, input bit [4:0] ev,
                                input bit rq, input bit [2:0] sel,
                                input bit ack, input int data, input bit rovf);
        vec_t t;
        t.sn = sn; t.hl = hl; t.ev = ev; t.cl = '0; t.rq = rq; t.sel = sel;
        t.ack = ack; t.data = data; t.rovf = rovf;
        return t;
    endfunction

    initial begin
        int acks;

        start_n = 1'b0;
        halt    = 1'b0;
        evt_en  = '0;
        clr     = '0;
        rd_req  = 1'b0;
        rd_sel  = '0;

        // Reset then ten counted cycles, read channel 0.
        repeat (2)  tbl.push_back(mk(0, 0, 5'h00, 0, 0, 0, 0, 0));
        repeat (10) tbl.push_back(mk(1, 0, 5'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5'h00, 1, 0, 1, 10, 0));
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 0, 10, 0));
        // Halt freeze: 5 counted, 7 halted with events, 3 counted.
        tbl.push_back(mk(0, 0, 5'h00, 0, 0, 0, 0, 0));
        repeat (5) tbl.push_back(mk(1, 0, 5'h00, 0, 0, 0, 0, 0));
        repeat (7) tbl.push_back(mk(1, 1, 5'h1F, 0, 0, 0, 0, 0));
        repeat (3) tbl.push_back(mk(1, 0, 5'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5'h00, 1, 0, 1, 8, 0));
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 0, 8, 0));
        tbl.push_back(mk(1, 0, 5'h00, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            start_n = tbl[i].sn;
            halt    = tbl[i].hl;
            evt_en  = tbl[i].ev;
            clr     = tbl[i].cl;
            rd_req  = tbl[i].rq;
            rd_sel  = tbl[i].sel;
            step();
            check($sformatf("tbl%0d_ack", i),  int'(ack_w),  int'(tbl[i].ack));
            check($sformatf("tbl%0d_data", i), int'(data_w), tbl[i].data);
            check($sformatf("tbl%0d_rovf", i), int'(rovf_w), int'(tbl[i].rovf));
        end

        // Wrap: 17 events on channel 1, then clear.
        do_reset(1);
        pulse_evt(1, 17);
        read_expect("wrap_rd", 1, 1, 1, 15, 1);
        check("wrap_ovf1", int'(ovf_w[1]), 1);
        clr = 5'b00010;
        step();
        clr = '0;
        read_expect("wrap_clr", 1, 0, 0, 0, 0);

        // Saturate: 20 events on channel 2.
        do_reset(1);
        pulse_evt(2, 20);
        read_expect("sat_rd", 2, 4, 1, 15, 1);

        // Simultaneous clear and increment, read on an increment edge, held request.
        do_reset(1);
        evt_en = 5'b01000;
        clr    = 5'b01000;
        step();
        evt_en = '0;
        clr    = '0;
        read_expect("sim_clr", 3, 0, 0, 0, 0);
        pulse_evt(3, 6);
        evt_en = 5'b01000;
        read_expect("sim_rdinc", 3, 6, 0, 6, 0);
        evt_en = '0;
        read_expect("sim_post", 3, 8, 0, 8, 0);
        acks   = 0;
        rd_req = 1'b1;
        rd_sel = '0;
        repeat (6) begin
            step();
            acks += int'(ack_w);
        end
        rd_req = 1'b0;
        check("hold_acks", acks, 3);

        // Reset during an acknowledge, then invalid selects.
        rd_req = 1'b1;
        rd_sel = 3'd1;
        step();
        start_n = 1'b0;
        rd_req  = 1'b0;
        step();
        check("rst_ack", int'(ack_w), 0);
        check("rst_data", int'(data_w), 0);
        start_n = 1'b1;
        read_expect("rst_c0", 0, 0, 0, 0, 0);
        for (int c = 1; c < CH; c++) read_expect($sformatf("rst_c%0d", c), c, 0, 0, 0, 0);
        read_expect("pre_inv", 0, 10, 0, 10, 0);
        read_expect("inv_sel5", CH, 0, 0, 0, 0);
        read_expect("pre_inv2", 0, 14, 0, 14, 0);
        read_expect("inv_sel7", 7, 0, 0, 0, 0);

        // Random traffic against the model.
        repeat (3000) begin
            start_n = ($urandom_range(0, 99) >= 3);
            halt    = ($urandom_range(0, 99) < 20);
            evt_en  = CH'($urandom);
            for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(0, 99) < 8);
            rd_req  = $urandom_range(0, 1) == 1;
            rd_sel  = SW'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of event/cycle counters for the ACDC core, generalising the core's single 16-bit cycle counter. Channel 0 counts every non-halted clock cycle. Channels 1..CHANNELS-1 count core events such as branches taken, memory reads, memory writes and overflow sets. Each channel has per-channel clear, wrap or saturate overflow mode, and sticky overflow flags. A one-deep request/acknowledge port reads counters out so the testbench or a debug path can sample counts without stopping the core.

## Interface
- WIDTH, 16, counter width in bits (2..32)
- CHANNELS, 4, number of counters including the cycle counter (2..16)
- SATURATE, 0, 0: counters wrap to 0 on overflow; 1: counters hold at 2^WIDTH-1
- CLK  in  1  clock, all state updates on posedge
- start_n  in  1  synchronous active-low reset; clears all state on the first posedge where it is low
- halt  in  1  core done flag; while high, no counter increments
- evt_en  in  CHANNELS  per-channel increment request; bit 0 is ignored because channel 0 counts cycles
- clr  in  CHANNELS  per-channel synchronous clear of the count and its sticky overflow flag
- rd_req  in  1  read request, sampled on posedge
- rd_sel  in  max(1,$clog2(CHANNELS))  channel index, sampled together with rd_req
- rd_ack  out  1  one-cycle pulse: rd_data and rd_ovf are valid
- rd_data  out  WIDTH  count captured for the request
- rd_ovf  out  1  overflow flag captured for the request
- ovf  out  CHANNELS  live sticky overflow flags

## Operation
- Counter update per channel i, applied each posedge when start_n=1. Priority: clr[i] > hold (halt=1) > increment > hold.
- Increment condition: channel 0 when halt=0; channel i>0 when halt=0 and evt_en[i]=1.
- Wrap mode (SATURATE=0):
  - count at 2^WIDTH-1 plus an increment gives 0.
  - ovf[i] sets on that same edge.
- Saturate mode (SATURATE=1):
  - count at 2^WIDTH-1 plus an increment stays at 2^WIDTH-1.
  - ovf[i] sets on the first increment attempted at max.
- ovf[i] stays set until clr[i] or reset. clr[i] wins over a same-cycle overflow.
- Read FSM has two states, IDLE and ACK.
  - IDLE: on rd_req=1 with rd_sel<CHANNELS, capture count[rd_sel] and ovf[rd_sel] into the output registers and go to ACK.
  - IDLE: on rd_sel>=CHANNELS, capture rd_data=0 and rd_ovf=0 and still go to ACK.
  - ACK: rd_ack=1 for exactly this cycle; return to IDLE unconditionally.
  - ACK: rd_req is ignored; the requester must re-issue it.
- Captured value is the register value before that edge's update. An increment or clear on the request edge is not visible in the captured value.
- rd_data and rd_ovf hold their last captured value until the next capture.

## Timing
- Reset (start_n=0 at a posedge): all counts=0, ovf=0, FSM=IDLE, rd_ack=0, rd_data=0, rd_ovf=0.
- Reset overrides every other input, including a request in flight. If start_n=0 while the FSM is in ACK, rd_ack is 0 on the next cycle.
- Counter latency: an input sampled at edge k is reflected in the count after edge k. Channel 0 reads k after k non-halted cycles following reset release.
- Read latency: rd_req high at edge k gives rd_ack=1 during cycle k+1 and rd_ack=0 after edge k+2.
  - Back-to-back maximum throughput is one read every 2 cycles.
  - A rd_req held high continuously produces an ack every other cycle.
- halt is sampled per edge; there is no latching. Counting resumes on the first edge where halt=0.
- Simultaneous events on one channel in the same cycle: clr together with increment gives 0. Increment at max together with clr gives count 0 and ovf 0.
- All outputs come from registers; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and cycle count: hold start_n=0 for 2 cycles, release, keep halt=0 for 10 cycles, then request channel 0 with rd_sel=0. Required: rd_ack one cycle later with rd_data=10 (count before the request edge), rd_ovf=0.
- Halt freeze: after 5 counted cycles, raise halt for 7 cycles and drop it for 3 cycles, then read channel 0. Required: rd_data=8. evt_en pulses issued during halt are not counted.
- Wrap overflow: with WIDTH=4 and SATURATE=0, pulse evt_en[1] 17 times, then read channel 1. Required: rd_data=1, rd_ovf=1, ovf[1]=1. Then assert clr[1] and read again. Required: rd_data=0, rd_ovf=0.
- Saturate: with WIDTH=4 and SATURATE=1, pulse evt_en[2] 20 times. Required: rd_data=15, rd_ovf=1.
- Simultaneous events:
  - Assert clr[3] and evt_en[3] together. Required: count stays 0.
  - Assert rd_req on the same edge as an increment of channel 3 from 6 to 7. Required: rd_data=6.
  - Hold rd_req high for 6 cycles. Required: exactly 3 acks.
- Reset mid-read and invalid select: drive start_n=0 on the edge after rd_req. Required: rd_ack=0 and all counts 0. Then request rd_sel=CHANNELS. Required: rd_ack=1, rd_data=0.
